dly_sched: RTL
==============

# dly_sched

Multi-channel delay scheduler that replaces N dedicated fixed-length delay counters with one shared free-running time base and per-channel deadline registers. Each channel is a retriggerable, cancellable delay line with a run-time programmable length, producing a one-cycle pulse and a busy level compatible with the existing fixed delay blocks. It sits between the control-pulse logic and consumers of timed pulses, and adds a serialized event output for a single shared consumer. Time unit is one `clk` period (20 ns at 50 MHz).

## Interface
- `N`, 4: number of channels (1..16).
- `W`, 16: time-base and delay width in bits. The maximum delay is 2^W-1 cycles.

- `clk`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `trig`  in  N  per-channel start/restart request, sampled each edge.
- `cancel`  in  N  per-channel abort request.
- `dly`  in  N*W  per-channel delay in cycles. Channel i occupies bits [i*W +: W]. Sampled only when `trig[i]` is high.
- `hold`  in  1  freezes the time base and suppresses firing (single-step/maintenance).
- `p`  out  N  one-cycle completion pulse per channel.
- `l`  out  N  per-channel active level.
- `busy`  out  1  OR of `l`.
- `ev_valid`  out  1  at least one channel fires this cycle.
- `ev_id`  out  4  index of the lowest-numbered firing channel. Value is 0 when `ev_valid` is low.
- `ev_multi`  out  1  two or more channels fire this cycle.

## Operation
- State:
  - `now`: W-bit counter. Increments every cycle when `hold` is low and wraps modulo 2^W.
  - Per channel: `active[i]` (drives `l[i]`) and `deadline[i]` (W bits).
- Arm: `trig[i]` high and `dly[i]` nonzero → `deadline[i]` ← `now` + `dly[i]` (mod 2^W), `active[i]` ← 1.
  - A retrigger while active restarts the channel with the new deadline. No pulse is produced for the abandoned deadline.
- `dly[i]` = 0 with `trig[i]` high: the trigger is ignored and the channel state is unchanged.
- Fire: `p[i]` = `active[i]` & (`now` == `deadline[i]`) & ~`hold` & ~`cancel[i]`. This is combinational from registers and the two inputs.
  - At the edge where `p[i]` is high, `active[i]` ← 0, unless `trig[i]` re-arms the channel at that same edge.
- Cancel: `cancel[i]` high and `trig[i]` low → `active[i]` ← 0, and no pulse is produced that cycle.
- Simultaneous events on one channel:
  - `trig` with `cancel`: trig wins (re-arm).
  - `trig` with a fire: the pulse is emitted and the channel re-arms.
  - `cancel` with a would-be fire: the pulse is suppressed.
- Wrap-around: the equality compare is modulo 2^W, so deadlines crossing `now` wrap fire correctly for every `dly` in 1..2^W-1.
- Event port:
  - `ev_valid` = OR of `p`.
  - `ev_id` = priority encode of `p`, lowest index first.
  - `ev_multi` = popcount(`p`) ≥ 2.
  - All other channels' pulses remain visible on `p`, so no event is lost.
- Reset, also when applied mid-operation: `now`=0, all `active`=0, all `deadline`=0. Every output is 0 during the cycle after the reset edge, and no pulse is ever emitted for a delay armed before reset.

## Timing
- `trig[i]` sampled high in cycle c with `dly`=D and `hold` low throughout:
  - `l[i]` is high in cycles c+1 .. c+D.
  - `p[i]` is high in cycle c+D only.
  - This matches the latency of the fixed delay blocks, where D counts equal the compare value.
- Each cycle with `hold` high inside the window extends both `l[i]` and the `p[i]` position by one cycle.
- A trigger is accepted while `hold` is high. Its deadline is computed from the frozen `now`.
- `ev_*` outputs have the same cycle timing as `p`.
- `busy` follows `l` with no added latency.
- Throughput: each channel can be re-armed every cycle. There is no back-pressure.

## Test plan
- Reset release, then `trig[0]` in cycle 10 with D=50 → `p[0]` high only in cycle 60; `l[0]` high in cycles 11..60; `ev_valid`=1 and `ev_id`=0 in cycle 60.
- Wrap-around: force `now` to 2^W-3, then `trig[1]` with D=5 → `p[1]` exactly 5 cycles later, after `now` has wrapped to 2. Also D=2^W-1 → fires after 65535 cycles.
- Retrigger and cancel:
  - Channel 2: D=20 at cycle 0, retrigger D=10 at cycle 15 → single `p[2]` at cycle 25.
  - Channel 3: D=8, `cancel[3]` in cycle 8 → no pulse, `l[3]` low from cycle 9.
- Collisions:
  - Channels 1 and 3 both fire in the same cycle → `p`=4'b1010, `ev_id`=1, `ev_multi`=1.
  - `trig` and fire coincide on channel 0 → pulse emitted and `l[0]` stays high.
- Hold: D=10 with `hold` high for 3 cycles mid-window → pulse at c+13, and no pulse while `hold` is high.
- Edge cases:
  - D=0 trigger → no state change.
  - D=1 → `p` in c+1.
  - `reset` asserted low with 4 channels armed → all outputs 0 the next cycle and no later pulses.

Source files
------------

// File: rtl/dly_sched.sv
// Multi-channel delay scheduler: one shared free-running time base, per-channel
// deadline compare, and a priority-encoded event port over the per-channel pulses.

module dly_chan #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] now,
  input  logic [W-1:0] dly,
  input  logic         trig,
  input  logic         cancel,
  input  logic         hold,
  output logic         p,
  output logic         l
);
  logic         active;
  logic [W-1:0] deadline;
  logic         fire;

  assign fire = active & (now == deadline) & ~hold & ~cancel;
  assign p    = fire;
  assign l    = active;

  // Re-arm beats both cancel and completion; a zero-length trigger is a no-op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      active   <= 1'b0;
      deadline <= '0;
    end else if (trig && (dly != '0)) begin
      active   <= 1'b1;
      deadline <= now + dly;
    end else if (cancel || fire) begin
      active   <= 1'b0;
    end
  end
endmodule

module dly_sched #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   trig,
  input  logic [N-1:0]   cancel,
  input  logic [N*W-1:0] dly,
  input  logic           hold,
  output logic [N-1:0]   p,
  output logic [N-1:0]   l,
  output logic           busy,
  output logic           ev_valid,
  output logic [3:0]     ev_id,
  output logic           ev_multi
);
  logic [W-1:0]        now;
  logic [N-1:0][W-1:0] dly_v;
  logic [4:0]          fire_cnt;

  assign dly_v = dly;

  always_ff @(posedge clk) begin
    if (!reset)     now <= '0;
    else if (!hold) now <= now + 1'b1;
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    dly_chan #(.W(W)) u_chan (
      .clk    (clk),
      .reset  (reset),
      .now    (now),
      .dly    (dly_v[i]),
      .trig   (trig[i]),
      .cancel (cancel[i]),
      .hold   (hold),
      .p      (p[i]),
      .l      (l[i])
    );
  end

  assign busy     = |l;
  assign ev_valid = |p;
  assign ev_multi = (fire_cnt >= 5'd2);

  // Scan high to low so the lowest firing index is the one left in ev_id.
  always_comb begin
    ev_id    = '0;
    fire_cnt = '0;
    for (int i = N - 1; i >= 0; i--)
      if (p[i]) ev_id = 4'(i);
    for (int i = 0; i < N; i++)
      fire_cnt = fire_cnt + 5'(p[i]);
  end
endmodule
